// File: rtl/spd_pkg.sv
// Shared types, defaults and trellis helpers for the 4-state register-exchange survivor decoder.
package spd_pkg;

   localparam int unsigned NUM_STATES     = 4;
   localparam int unsigned PM_W_DEF       = 4;
   localparam int unsigned SURV_DEPTH_DEF = 8;

   typedef logic [1:0] state_t;

   // Predecessor of state n, given that state's ACS decision bit.
   function automatic state_t pred(input state_t n, input logic d);
      return {n[0], d};
   endfunction

endpackage

// File: rtl/spd_min_select.sv
// 4-input unsigned argmin over path metrics; ties resolve to the lowest index.
module spd_min_select
   import spd_pkg::*;
#(
   parameter int unsigned PM_W = PM_W_DEF
) (
   input  logic [PM_W-1:0] pm0,
   input  logic [PM_W-1:0] pm1,
   input  logic [PM_W-1:0] pm2,
   input  logic [PM_W-1:0] pm3,
   output state_t          best_c
);

   logic [PM_W-1:0] m01, m23;
   state_t          b01, b23;

   // Strict less-than keeps the lower index on equal metrics at every level.
   always_comb begin
      b01    = 2'd0;
      m01    = pm0;
      b23    = 2'd2;
      m23    = pm2;
      best_c = 2'd0;
      if (pm1 < pm0) begin
         b01 = 2'd1;
         m01 = pm1;
      end
      if (pm3 < pm2) begin
         b23 = 2'd3;
         m23 = pm3;
      end
      best_c = (m23 < m01) ? b23 : b01;
   end

endmodule

// File: rtl/spd.sv
// Register-exchange survivor-path decoder for a K=3 rate-1/2 Viterbi decoder.
module spd
   import spd_pkg::*;
#(
   parameter int unsigned SURV_DEPTH = SURV_DEPTH_DEF,
   parameter int unsigned PM_W       = PM_W_DEF
) (
   input  logic            d0,
   input  logic            d1,
   input  logic            d2,
   input  logic            d3,
   input  logic [PM_W-1:0] pm0,
   input  logic [PM_W-1:0] pm1,
   input  logic [PM_W-1:0] pm2,
   input  logic [PM_W-1:0] pm3,
   output logic            out,
   input  logic            clk,
   input  logic            reset
);

   logic [SURV_DEPTH-1:0] surv_q [NUM_STATES];
   logic [SURV_DEPTH-1:0] surv_d [NUM_STATES];
   logic                  out_q, out_d;
   logic [NUM_STATES-1:0] dec_c;
   state_t                best_c;
   state_t                ns, ps;

   assign dec_c = {d3, d2, d1, d0};

   spd_min_select #(.PM_W(PM_W)) u_min_select (
      .pm0    (pm0),
      .pm1    (pm1),
      .pm2    (pm2),
      .pm3    (pm3),
      .best_c (best_c)
   );

   // Every state inherits its predecessor's history and appends its own MSB.
   always_comb begin
      ns = 2'd0;
      ps = 2'd0;
      for (int unsigned n = 0; n < NUM_STATES; n++) begin
         surv_d[n] = '0;
      end
      for (int unsigned n = 0; n < NUM_STATES; n++) begin
         ns        = state_t'(n);
         ps        = pred(ns, dec_c[n]);
         surv_d[n] = {surv_q[ps][SURV_DEPTH-2:0], ns[1]};
      end
      out_d = surv_d[best_c][SURV_DEPTH-1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned n = 0; n < NUM_STATES; n++) begin
            surv_q[n] <= '0;
         end
         out_q <= 1'b0;
      end else begin
         for (int unsigned n = 0; n < NUM_STATES; n++) begin
            surv_q[n] <= surv_d[n];
         end
         out_q <= out_d;
      end
   end

   assign out = out_q;

endmodule

// File: tb/tb_spd.sv
// Directed and randomized checks of the survivor-path decoder against a queued expectation stream.
module tb_spd;

   logic       clk = 1'b0;
   logic       reset;
   logic       d0, d1, d2, d3;
   logic [3:0] pm0, pm1, pm2, pm3;
   logic       out;

   int total = 0;
   int bad   = 0;
   logic exp_q [$];

   // Reference survivors for the randomized phase.
   logic [7:0] m_surv [4];

   always #5 clk = ~clk;

   spd dut (
      .d0    (d0),
      .d1    (d1),
      .d2    (d2),
      .d3    (d3),
      .pm0   (pm0),
      .pm1   (pm1),
      .pm2   (pm2),
      .pm3   (pm3),
      .out   (out),
      .clk   (clk),
      .reset (reset)
   );

   task automatic set_in(input logic [3:0] d, input int p0, input int p1, input int p2, input int p3);
      {d3, d2, d1, d0} = d;
      pm0 = 4'(p0);
      pm1 = 4'(p1);
      pm2 = 4'(p2);
      pm3 = 4'(p3);
   endtask

   // Queue the expectation, take one edge, then compare clear of the edge.
   task automatic step(input string tag, input logic e);
      logic want;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      total++;
      assert (out === want) else begin
         bad++;
         $error("FAIL %s out=%0b expected=%0b", tag, out, want);
      end
   endtask

   task automatic steps(input string tag, input int n, input logic e);
      for (int i = 0; i < n; i++) step(tag, e);
   endtask

   // Independent trellis model: returns the expected out for the current inputs.
   function automatic logic model_step();
      logic [7:0] nx [4];
      logic [3:0] d;
      logic [3:0] pm [4];
      int         best;
      int         p;
      d  = {d3, d2, d1, d0};
      pm[0] = pm0; pm[1] = pm1; pm[2] = pm2; pm[3] = pm3;
      if (reset) begin
         for (int n = 0; n < 4; n++) m_surv[n] = 8'h00;
         return 1'b0;
      end
      for (int n = 0; n < 4; n++) begin
         p     = ((n & 1) << 1) | int'(d[n]);
         nx[n] = {m_surv[p][6:0], 1'((n >> 1) & 1)};
      end
      best = 0;
      for (int n = 1; n < 4; n++) if (pm[n] < pm[best]) best = n;
      for (int n = 0; n < 4; n++) m_surv[n] = nx[n];
      return nx[best][7];
   endfunction

   initial begin
      // Reset with arbitrary inputs.
      reset = 1'b1;
      set_in(4'b1011, 7, 3, 12, 0);
      step("reset", 1'b0);

      // Stable-zero path: best=2, its survivor MSB never becomes 1.
      set_in(4'b1010, 1, 1, 0, 1);
      step("zero_rst", 1'b0);
      reset = 1'b0;
      steps("zero_run", 30, 1'b0);

      // Latency: state 3 self-loops appending ones.
      reset = 1'b1;
      set_in(4'b1010, 1, 1, 1, 0);
      step("lat_rst", 1'b0);
      reset = 1'b0;
      steps("lat_pre", 7, 1'b0);
      steps("lat_post", 5, 1'b1);

      // Mid-stream reset discards history.
      reset = 1'b1;
      step("mid_rst", 1'b0);
      reset = 1'b0;
      steps("mid_pre", 7, 1'b0);
      steps("mid_post", 3, 1'b1);

      // Tie-break: equal metrics pick state 0.
      reset = 1'b1;
      set_in(4'b1010, 5, 5, 5, 5);
      step("tie_rst", 1'b0);
      reset = 1'b0;
      steps("tie_eq", 10, 1'b0);
      pm3 = 4'd4;
      steps("tie_pm3", 3, 1'b1);

      // Predecessor routing: state 1 inherits from state 3.
      reset = 1'b1;
      set_in(4'b1111, 9, 9, 9, 0);
      step("pred_rst", 1'b0);
      reset = 1'b0;
      steps("pred_pre", 7, 1'b0);
      steps("pred_s3", 2, 1'b1);
      set_in(4'b1111, 9, 0, 9, 9);
      steps("pred_s1", 4, 1'b1);

      // Randomized trellis traffic against the model.
      reset = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (i > 0) reset = ($urandom_range(0, 31) == 0);
         set_in(4'($urandom_range(0, 15)), $urandom_range(0, 15), $urandom_range(0, 15),
                $urandom_range(0, 15), $urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) begin
            pm1 = pm0;
            pm3 = pm0;
         end
         step("rand", model_step());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
